// File: rtl/wb_stage_if.sv
// MEM-to-WB retiring-instruction channel: valid/ready handshake plus the
// destination register, write-enable, load flag and ALU result it carries.
interface wb_stage_if;
  logic        MEM_Valid;
  logic        MEM_Ready;
  logic        MEM_RegWr;
  logic        MEM_MemtoReg;
  logic [4:0]  MEM_Rw;
  logic [31:0] MEM_ALUout;

  modport master (
    output MEM_Valid, MEM_RegWr, MEM_MemtoReg, MEM_Rw, MEM_ALUout,
    input  MEM_Ready
  );

  modport slave (
    input  MEM_Valid, MEM_RegWr, MEM_MemtoReg, MEM_Rw, MEM_ALUout,
    output MEM_Ready
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: one register-file write cycle per retired instruction, one cycle
// after accept (or after DM_Rdy for late loads); MEM_Ready drops only while awaiting load data.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  wb_stage_if.slave         mem,
  input  logic [31:0]       DM_Rdata,
  input  logic              DM_Rdy,
  output logic [4:0]        WB_Rw,
  output logic              WB_Reg_Wr,
  output logic [31:0]       BusW,
  output logic [CNT_W-1:0]  Retired
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state;
  logic   held_regwr;
  logic   accept;
  logic   mem_wr_en;
  logic   held_wr_en;

  assign mem.MEM_Ready = (state != S_WAIT);
  assign accept        = mem.MEM_Valid && mem.MEM_Ready;
  // r0 is hard-wired zero, so its writes are suppressed but still retire.
  assign mem_wr_en     = mem.MEM_RegWr && (mem.MEM_Rw != 5'd0);
  assign held_wr_en    = held_regwr && (WB_Rw != 5'd0);

  // WB_Rw and BusW double as the held Rw/data fields, so they keep their
  // last values outside the write cycle.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= S_EMPTY;
      held_regwr <= 1'b0;
      WB_Rw      <= 5'd0;
      BusW       <= 32'd0;
      WB_Reg_Wr  <= 1'b0;
      Retired    <= '0;
    end else begin
      WB_Reg_Wr <= 1'b0;
      if (state == S_WRITE) begin
        Retired <= Retired + CNT_W'(1);
      end
      case (state)
        S_EMPTY, S_WRITE: begin
          if (accept) begin
            WB_Rw      <= mem.MEM_Rw;
            held_regwr <= mem.MEM_RegWr;
            if (!mem.MEM_MemtoReg) begin
              BusW      <= mem.MEM_ALUout;
              WB_Reg_Wr <= mem_wr_en;
              state     <= S_WRITE;
            end else if (DM_Rdy) begin
              BusW      <= DM_Rdata;
              WB_Reg_Wr <= mem_wr_en;
              state     <= S_WRITE;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            state <= S_EMPTY;
          end
        end
        S_WAIT: begin
          if (DM_Rdy) begin
            BusW      <= DM_Rdata;
            WB_Reg_Wr <= held_wr_en;
            state     <= S_WRITE;
          end
        end
        default: begin
          state <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected register writes are queued at drive time and
// popped by a negedge monitor; a second CNT_W=4 instance covers counter wrap.
module tb_wb_stage;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] DM_Rdata;
  logic        DM_Rdy;
  logic [4:0]  WB_Rw;
  logic        WB_Reg_Wr;
  logic [31:0] BusW;
  logic [31:0] Retired;

  logic [31:0] w_DM_Rdata;
  logic        w_DM_Rdy;
  logic [4:0]  w_WB_Rw;
  logic        w_WB_Reg_Wr;
  logic [31:0] w_BusW;
  logic [3:0]  w_Retired;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  wb_stage_if mif ();
  wb_stage_if wif ();

  wb_stage #(.CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .mem(mif.slave),
    .DM_Rdata(DM_Rdata), .DM_Rdy(DM_Rdy),
    .WB_Rw(WB_Rw), .WB_Reg_Wr(WB_Reg_Wr), .BusW(BusW), .Retired(Retired)
  );

  wb_stage #(.CNT_W(4)) dut_w (
    .CLK(CLK), .Reset(Reset), .mem(wif.slave),
    .DM_Rdata(w_DM_Rdata), .DM_Rdy(w_DM_Rdy),
    .WB_Rw(w_WB_Rw), .WB_Reg_Wr(w_WB_Reg_Wr), .BusW(w_BusW), .Retired(w_Retired)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic vld, input logic regwr, input logic ld,
                       input logic [4:0] rw, input logic [31:0] alu);
    mif.MEM_Valid    = vld;
    mif.MEM_RegWr    = regwr;
    mif.MEM_MemtoReg = ld;
    mif.MEM_Rw       = rw;
    mif.MEM_ALUout   = alu;
  endtask

  // Scoreboard: every observed register write must match the oldest queued one.
  always @(negedge CLK) begin
    if (Reset && WB_Reg_Wr) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", {31'd0, WB_Reg_Wr}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_rw", {27'd0, WB_Rw}, {27'd0, e.rw});
        check("sb_busw", BusW, e.data);
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    DM_Rdata = 32'd0;
    DM_Rdy   = 1'b0;
    wif.MEM_Valid    = 1'b0;
    wif.MEM_RegWr    = 1'b0;
    wif.MEM_MemtoReg = 1'b0;
    wif.MEM_Rw       = 5'd0;
    wif.MEM_ALUout   = 32'd0;
    w_DM_Rdata = 32'd0;
    w_DM_Rdy   = 1'b0;

    // Reset held low: all outputs zero.
    #2 Reset = 1'b0;
    #2;
    check("rst_reg_wr", {31'd0, WB_Reg_Wr}, 32'd0);
    check("rst_rw", {27'd0, WB_Rw}, 32'd0);
    check("rst_busw", BusW, 32'd0);
    check("rst_retired", Retired, 32'd0);
    check("rst_w_retired", {28'd0, w_Retired}, 32'd0);
    cyc();
    cyc();
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_ready", {31'd0, mif.MEM_Ready}, 32'd1);
      check("idle_reg_wr", {31'd0, WB_Reg_Wr}, 32'd0);
    end

    // ALU stream: three back-to-back non-loads.
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h11); exp_q.push_back({5'd5, 32'h11});
    check("alu_ready0", {31'd0, mif.MEM_Ready}, 32'd1);
    cyc();
    check("alu_wr0", {31'd0, WB_Reg_Wr}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h22); exp_q.push_back({5'd6, 32'h22});
    check("alu_ready1", {31'd0, mif.MEM_Ready}, 32'd1);
    cyc();
    check("alu_wr1", {31'd0, WB_Reg_Wr}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h33); exp_q.push_back({5'd7, 32'h33});
    check("alu_ready2", {31'd0, mif.MEM_Ready}, 32'd1);
    cyc();
    check("alu_wr2", {31'd0, WB_Reg_Wr}, 32'd1);
    check("alu_rw2", {27'd0, WB_Rw}, 32'd7);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cyc();
    check("alu_retired", Retired, 32'd3);
    check("alu_idle_wr", {31'd0, WB_Reg_Wr}, 32'd0);

    // Delayed load: four cycles in WAIT, data arrives on the fourth.
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'hBAD); exp_q.push_back({5'd9, 32'hDEADBEEF});
    cyc();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("ld_wait_ready", {31'd0, mif.MEM_Ready}, 32'd0);
      check("ld_wait_wr", {31'd0, WB_Reg_Wr}, 32'd0);
      if (i == 3) begin
        DM_Rdy   = 1'b1;
        DM_Rdata = 32'hDEADBEEF;
      end
      cyc();
    end
    DM_Rdy = 1'b0;
    check("ld_wr", {31'd0, WB_Reg_Wr}, 32'd1);
    check("ld_rw", {27'd0, WB_Rw}, 32'd9);
    check("ld_busw", BusW, 32'hDEADBEEF);
    check("ld_ready_in_write", {31'd0, mif.MEM_Ready}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 5'd10, 32'h55); exp_q.push_back({5'd10, 32'h55});
    cyc();
    check("ld_next_wr", {31'd0, WB_Reg_Wr}, 32'd1);
    check("ld_next_busw", BusW, 32'h55);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cyc();
    check("ld_retired", Retired, 32'd5);

    // Load with data in the accept cycle: same latency as a non-load.
    drive(1'b1, 1'b1, 1'b1, 5'd12, 32'h0); exp_q.push_back({5'd12, 32'hCAFE0001});
    DM_Rdy = 1'b1; DM_Rdata = 32'hCAFE0001;
    cyc();
    DM_Rdy = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("fast_ld_wr", {31'd0, WB_Reg_Wr}, 32'd1);
    check("fast_ld_busw", BusW, 32'hCAFE0001);
    cyc();
    check("fast_ld_retired", Retired, 32'd6);

    // r0 write and a store both retire without a register write.
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h77);
    cyc();
    check("r0_wr", {31'd0, WB_Reg_Wr}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h99);
    cyc();
    check("store_wr", {31'd0, WB_Reg_Wr}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cyc();
    check("r0_store_retired", Retired, 32'd8);

    // Spurious DM_Rdy in EMPTY is ignored.
    DM_Rdy = 1'b1; DM_Rdata = 32'h5A5A5A5A;
    cyc();
    DM_Rdy = 1'b0;
    check("spur_wr", {31'd0, WB_Reg_Wr}, 32'd0);
    check("spur_ready", {31'd0, mif.MEM_Ready}, 32'd1);
    cyc();
    check("spur_retired", Retired, 32'd8);

    // Reset during WAIT drops the pending load.
    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("rw_wait_ready", {31'd0, mif.MEM_Ready}, 32'd0);
    #1 Reset = 1'b0;
    #1 Reset = 1'b1;
    check("rw_ready", {31'd0, mif.MEM_Ready}, 32'd1);
    check("rw_retired0", Retired, 32'd0);
    DM_Rdy = 1'b1; DM_Rdata = 32'h1234;
    cyc();
    DM_Rdy = 1'b0;
    check("rw_no_wr", {31'd0, WB_Reg_Wr}, 32'd0);
    cyc();
    check("rw_no_wr2", {31'd0, WB_Reg_Wr}, 32'd0);
    check("rw_retired", Retired, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    // Counter wrap on the 4-bit instance: 17 retirements leave 1.
    wif.MEM_Valid = 1'b1;
    wif.MEM_RegWr = 1'b0;
    wif.MEM_Rw    = 5'd2;
    for (int i = 0; i < 17; i++) begin
      cyc();
    end
    wif.MEM_Valid = 1'b0;
    cyc();
    check("wrap_retired", {28'd0, w_Retired}, 32'd1);
    w_DM_Rdy = 1'b1; w_DM_Rdata = 32'hFFFF0000;
    cyc();
    w_DM_Rdy = 1'b0;
    check("wrap_spur_wr", {31'd0, w_WB_Reg_Wr}, 32'd0);
    cyc();
    check("wrap_spur_retired", {28'd0, w_Retired}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline: the producing end of the register-file write port that the decode stage consumes. Accepts one retiring instruction per cycle from the MEM stage with a valid/ready handshake, waits a variable number of cycles for load data from data memory, and drives `WB_Rw`, `WB_Reg_Wr`, `BusW` into the register file for exactly one cycle per instruction. Also keeps a retired-instruction counter.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `MEM_Valid` in 1: MEM stage presents an instruction this cycle.
- `MEM_Ready` out 1: WB accepts it this cycle. Transfer happens when `MEM_Valid && MEM_Ready` at the edge.
- `MEM_RegWr` in 1: instruction writes a register.
- `MEM_MemtoReg` in 1: result comes from data memory (load).
- `MEM_Rw` in 5: destination register.
- `MEM_ALUout` in 32: ALU result for non-loads.
- `DM_Rdata` in 32: load data; valid when `DM_Rdy`=1.
- `DM_Rdy` in 1: one-cycle pulse marking returned load data.
- `WB_Rw` out 5: register-file write address.
- `WB_Reg_Wr` out 1: register-file write enable.
- `BusW` out 32: register-file write data.
- `Retired` out CNT_W: count of committed instructions.

## Operation
- Three states: EMPTY, WAIT, WRITE. Held fields: Rw, RegWr, data.
- EMPTY:
  - `MEM_Ready`=1.
  - On accept of a non-load: latch `MEM_Rw`, `MEM_RegWr`, `MEM_ALUout`; go to WRITE.
  - On accept of a load with `DM_Rdy`=1 in the same cycle: latch `DM_Rdata`; go to WRITE.
  - On accept of a load with `DM_Rdy`=0: latch Rw and RegWr; go to WAIT.
- WAIT:
  - `MEM_Ready`=0.
  - On `DM_Rdy`: latch `DM_Rdata`; go to WRITE.
  - Otherwise stay in WAIT, with no timeout.
- WRITE:
  - `WB_Reg_Wr` = held RegWr && (held Rw != 0).
  - `WB_Rw` = held Rw; `BusW` = held data.
  - `Retired` increments at the closing edge.
  - `MEM_Ready`=1, so back-to-back acceptance is allowed with the same accept rules as EMPTY.
  - With no accept, go to EMPTY.
- Outside WRITE: `WB_Reg_Wr`=0. `WB_Rw` and `BusW` hold their last values; they are don't-care for the register file.
- Writes to r0 are suppressed, but the instruction still counts as retired.
- Stores and branches (RegWr=0) pass through WRITE with `WB_Reg_Wr`=0 and are counted.
- `DM_Rdy` is ignored in EMPTY and in WRITE unless it arrives in the same cycle a load is accepted.
- `Retired` wraps modulo 2^CNT_W.

## Timing
- Reset asserted, asynchronously:
  - state = EMPTY;
  - `WB_Reg_Wr`=0, `WB_Rw`=0, `BusW`=0, `Retired`=0;
  - `MEM_Ready`=1 once released.
  - Reset mid-WAIT drops the pending load, and a later `DM_Rdy` is ignored.
- Non-load latency: accepted at edge k, write cycle is k..k+1; the register file captures at edge k+1.
- Load latency:
  - `DM_Rdy` in the accept cycle gives the same latency as a non-load.
  - Otherwise the write cycle follows the `DM_Rdy` edge.
- Throughput: one instruction per cycle when there are no load waits.
- `MEM_Ready` is a combinational function of state only; it does not depend on `MEM_Valid`.
- Register-file write-before-read bypass is the decode stage's responsibility. WB holds its outputs stable for the full WRITE cycle.

## Test plan
- Reset then idle:
  - with `Reset` low, all outputs are 0;
  - after release, `MEM_Ready`=1 and `WB_Reg_Wr` stays 0 for 10 cycles with `MEM_Valid`=0.
- ALU stream:
  - 3 back-to-back non-loads: Rw=5/ALU=0x11, Rw=6/0x22, Rw=7/0x33.
  - Expect `WB_Reg_Wr`=1 on 3 consecutive cycles with matching `WB_Rw`/`BusW`.
  - `MEM_Ready` stays 1; `Retired`=3.
- Delayed load:
  - load Rw=9, `DM_Rdy` asserted 4 cycles later with `DM_Rdata`=0xDEADBEEF.
  - `MEM_Ready`=0 for those 4 cycles.
  - The next cycle shows `WB_Rw`=9, `BusW`=0xDEADBEEF, `WB_Reg_Wr`=1.
  - A following non-load is accepted in that write cycle.
- r0 and store:
  - non-load Rw=0/RegWr=1 gives `WB_Reg_Wr`=0.
  - A store (RegWr=0) gives `WB_Reg_Wr`=0.
  - `Retired` advances by 2.
- Reset mid-WAIT:
  - load Rw=4 accepted, `Reset` pulsed low in WAIT, then `DM_Rdy` pulses.
  - Expect no write, `Retired`=0, `MEM_Ready`=1.
- Wrap:
  - with `CNT_W`=4, retire 17 instructions; `Retired`=1.
  - Spurious `DM_Rdy` in EMPTY causes no write.
